// File: rtl/cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_pkg
// Description : Shared types and constants for the direct-mapped cache
//               controller: FSM encoding, status bits, default geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_ctrl_pkg;

  localparam int DEF_TAG_LEN    = 13;
  localparam int DEF_INDEX_LEN  = 10;
  localparam int DEF_OFFSET_LEN = 4;

  localparam int STATUS_W         = 3;
  localparam int STATUS_VALID_BIT = 0;
  localparam int STATUS_DIRTY_BIT = 1;

  localparam logic [STATUS_W-1:0] STATUS_VALID = 3'b001;
  localparam logic [STATUS_W-1:0] STATUS_DIRTY = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_WB        = 3'd2,
    ST_FILL_REQ  = 3'd3,
    ST_FILL_WAIT = 3'd4,
    ST_UPDATE    = 3'd5,
    ST_RESP      = 3'd6
  } state_t;

  // Line width in bits for a given byte-offset width (32-bit words).
  function automatic int line_width(input int offset_len);
    return 32 << (offset_len - 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_if
// Description : Bus bundle of the cache controller: CPU request/response,
//               status/tag RAM, data RAM, line writeback and line fill.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_ctrl_if #(
  parameter int TAG_LEN    = cache_ctrl_pkg::DEF_TAG_LEN,
  parameter int INDEX_LEN  = cache_ctrl_pkg::DEF_INDEX_LEN,
  parameter int OFFSET_LEN = cache_ctrl_pkg::DEF_OFFSET_LEN
);
  localparam int LINE_W  = cache_ctrl_pkg::line_width(OFFSET_LEN);
  localparam int ADDR_W  = TAG_LEN + INDEX_LEN + OFFSET_LEN;
  localparam int MADDR_W = TAG_LEN + INDEX_LEN;

  logic                 req_valid;
  logic                 req_we;
  logic [ADDR_W-1:0]    req_addr;
  logic [31:0]          req_wdata;
  logic                 req_ready;
  logic                 resp_valid;
  logic [31:0]          resp_rdata;

  logic                 st_we;
  logic                 st_re;
  logic [INDEX_LEN-1:0] st_addr;
  logic [TAG_LEN-1:0]   st_tag_in;
  logic [2:0]           st_status_in;
  logic [TAG_LEN-1:0]   st_tag_out;
  logic [2:0]           st_status_out;

  logic                 d_we;
  logic                 d_re;
  logic [INDEX_LEN-1:0] d_addr;
  logic [LINE_W-1:0]    d_in;
  logic [LINE_W-1:0]    d_out;

  logic                 mem_wvalid;
  logic [MADDR_W-1:0]   mem_waddr;
  logic [LINE_W-1:0]    mem_wdata;
  logic                 mem_wready;

  logic                 mem_rvalid_req;
  logic [MADDR_W-1:0]   mem_raddr;
  logic                 mem_rready;
  logic                 mem_rvalid;
  logic [LINE_W-1:0]    mem_rdata;

  // Controller side
  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata,
    output st_we, st_re, st_addr, st_tag_in, st_status_in,
    input  st_tag_out, st_status_out,
    output d_we, d_re, d_addr, d_in,
    input  d_out,
    output mem_wvalid, mem_waddr, mem_wdata,
    input  mem_wready,
    output mem_rvalid_req, mem_raddr,
    input  mem_rready, mem_rvalid, mem_rdata
  );

  // CPU, RAM and memory side
  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata,
    input  st_we, st_re, st_addr, st_tag_in, st_status_in,
    output st_tag_out, st_status_out,
    input  d_we, d_re, d_addr, d_in,
    output d_out,
    input  mem_wvalid, mem_waddr, mem_wdata,
    output mem_wready,
    input  mem_rvalid_req, mem_raddr,
    output mem_rready, mem_rvalid, mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/cache_word_sel.sv
`default_nettype none
// ============================================================================
// Module      : cache_word_sel
// Description : Combinational 32-bit word extract from a cache line and
//               word merge into a line, selected by the word offset.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_word_sel
  import cache_ctrl_pkg::*;
#(
  parameter int OFFSET_LEN = DEF_OFFSET_LEN
) (
  input  logic [line_width(OFFSET_LEN)-1:0] i_line,
  input  logic [OFFSET_LEN-3:0]             i_wsel,
  input  logic [31:0]                       i_wdata,
  output logic [31:0]                       o_word,
  output logic [line_width(OFFSET_LEN)-1:0] o_merged
);
  localparam int WSEL_W = OFFSET_LEN - 2;
  localparam int NWORDS = 1 << WSEL_W;

  logic [31:0] w_words [NWORDS];

  for (genvar g = 0; g < NWORDS; g++) begin : g_word
    assign w_words[g]           = i_line[g*32 +: 32];
    assign o_merged[g*32 +: 32] = (i_wsel == WSEL_W'(g)) ? i_wdata : i_line[g*32 +: 32];
  end

  assign o_word = w_words[i_wsel];

endmodule
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl
// Description : Direct-mapped, write-back, write-allocate cache controller.
//               Define CACHE_CTRL_STATS_EN to add hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int TAG_LEN    = DEF_TAG_LEN,
  parameter int INDEX_LEN  = DEF_INDEX_LEN,
  parameter int OFFSET_LEN = DEF_OFFSET_LEN
) (
  input  logic        clk,
  input  logic        reset,
`ifdef CACHE_CTRL_STATS_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  cache_ctrl_if.master bus
);
  localparam int LINE_W = line_width(OFFSET_LEN);
  localparam int ADDR_W = TAG_LEN + INDEX_LEN + OFFSET_LEN;
  localparam int WSEL_W = OFFSET_LEN - 2;

  state_t               r_state;
  state_t               w_next;

  logic                 r_we;
  logic [TAG_LEN-1:0]   r_tag;
  logic [INDEX_LEN-1:0] r_index;
  logic [WSEL_W-1:0]    r_wsel;
  logic [31:0]          r_wdata;
  logic [LINE_W-1:0]    r_line;
  logic [TAG_LEN-1:0]   r_old_tag;
  logic [31:0]          r_rdata;

  logic [INDEX_LEN-1:0] w_req_index;
  logic                 w_hit;
  logic                 w_victim_dirty;
  logic [LINE_W-1:0]    w_sel_line;
  logic [31:0]          w_word;
  logic [LINE_W-1:0]    w_merged;

  assign w_req_index    = bus.req_addr[OFFSET_LEN +: INDEX_LEN];
  assign w_hit          = bus.st_status_out[STATUS_VALID_BIT] && (bus.st_tag_out == r_tag);
  assign w_victim_dirty = bus.st_status_out[STATUS_VALID_BIT] && bus.st_status_out[STATUS_DIRTY_BIT];

  // LOOKUP works on the line just read from RAM; UPDATE on the fetched line.
  assign w_sel_line = (r_state == ST_LOOKUP) ? bus.d_out : r_line;

  cache_word_sel #(
    .OFFSET_LEN (OFFSET_LEN)
  ) u_word_sel (
    .i_line   (w_sel_line),
    .i_wsel   (r_wsel),
    .i_wdata  (r_wdata),
    .o_word   (w_word),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next             = r_state;
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.resp_rdata     = '0;
    bus.st_we          = 1'b0;
    bus.st_re          = 1'b0;
    bus.st_addr        = '0;
    bus.st_tag_in      = '0;
    bus.st_status_in   = '0;
    bus.d_we           = 1'b0;
    bus.d_re           = 1'b0;
    bus.d_addr         = '0;
    bus.d_in           = '0;
    bus.mem_wvalid     = 1'b0;
    bus.mem_waddr      = '0;
    bus.mem_wdata      = '0;
    bus.mem_rvalid_req = 1'b0;
    bus.mem_raddr      = '0;

    case (r_state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          bus.st_re   = 1'b1;
          bus.d_re    = 1'b1;
          bus.st_addr = w_req_index;
          bus.d_addr  = w_req_index;
          w_next      = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        if (w_hit) begin
          if (r_we) begin
            bus.st_we        = 1'b1;
            bus.d_we         = 1'b1;
            bus.st_addr      = r_index;
            bus.d_addr       = r_index;
            bus.st_tag_in    = r_tag;
            bus.st_status_in = STATUS_VALID | STATUS_DIRTY;
            bus.d_in         = w_merged;
          end
          w_next = ST_RESP;
        end else if (w_victim_dirty) begin
          w_next = ST_WB;
        end else begin
          w_next = ST_FILL_REQ;
        end
      end

      ST_WB: begin
        bus.mem_wvalid = 1'b1;
        bus.mem_waddr  = {r_old_tag, r_index};
        bus.mem_wdata  = r_line;
        if (bus.mem_wready) begin
          w_next = ST_FILL_REQ;
        end
      end

      ST_FILL_REQ: begin
        bus.mem_rvalid_req = 1'b1;
        bus.mem_raddr      = {r_tag, r_index};
        if (bus.mem_rready) begin
          w_next = ST_FILL_WAIT;
        end
      end

      ST_FILL_WAIT: begin
        if (bus.mem_rvalid) begin
          w_next = ST_UPDATE;
        end
      end

      ST_UPDATE: begin
        bus.st_we        = 1'b1;
        bus.d_we         = 1'b1;
        bus.st_addr      = r_index;
        bus.d_addr       = r_index;
        bus.st_tag_in    = r_tag;
        bus.st_status_in = r_we ? (STATUS_VALID | STATUS_DIRTY) : STATUS_VALID;
        bus.d_in         = r_we ? w_merged : r_line;
        w_next           = ST_RESP;
      end

      ST_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = r_rdata;
        w_next         = ST_IDLE;
      end

      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Request capture and line/response datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we      <= 1'b0;
      r_tag     <= '0;
      r_index   <= '0;
      r_wsel    <= '0;
      r_wdata   <= '0;
      r_line    <= '0;
      r_old_tag <= '0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_we    <= bus.req_we;
            r_tag   <= bus.req_addr[ADDR_W-1 -: TAG_LEN];
            r_index <= w_req_index;
            r_wsel  <= bus.req_addr[OFFSET_LEN-1:2];
            r_wdata <= bus.req_wdata;
          end
        end
        ST_LOOKUP: begin
          if (w_hit) begin
            r_rdata <= r_we ? 32'd0 : w_word;
          end else begin
            r_line    <= bus.d_out;
            r_old_tag <= bus.st_tag_out;
          end
        end
        ST_FILL_WAIT: begin
          if (bus.mem_rvalid) begin
            r_line <= bus.mem_rdata;
          end
        end
        ST_UPDATE: begin
          r_rdata <= r_we ? 32'd0 : w_word;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == ST_LOOKUP) begin
      if (w_hit) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_ctrl
// Description : Directed self-checking bench for cache_ctrl with RAM and
//               memory models and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl;
  import cache_ctrl_pkg::*;

  localparam int TAG_LEN    = 13;
  localparam int INDEX_LEN  = 10;
  localparam int OFFSET_LEN = 4;
  localparam int LINE_W     = 128;
  localparam int MADDR_W    = 23;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cache_ctrl_if #(.TAG_LEN(TAG_LEN), .INDEX_LEN(INDEX_LEN), .OFFSET_LEN(OFFSET_LEN)) bus ();

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  cache_ctrl #(.TAG_LEN(TAG_LEN), .INDEX_LEN(INDEX_LEN), .OFFSET_LEN(OFFSET_LEN)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef CACHE_CTRL_STATS_EN
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
`endif
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Status/tag and data RAM models with one-cycle read latency
  logic [TAG_LEN-1:0] tag_ram  [1024];
  logic [2:0]         stat_ram [1024];
  logic [LINE_W-1:0]  data_ram [1024];
  int st_we_cnt = 0, d_we_cnt = 0, proto_err = 0;

  always @(posedge clk) begin
    if (bus.st_we) begin
      tag_ram[bus.st_addr]  <= bus.st_tag_in;
      stat_ram[bus.st_addr] <= bus.st_status_in;
      st_we_cnt <= st_we_cnt + 1;
    end
    if (bus.st_re) begin
      bus.st_tag_out    <= tag_ram[bus.st_addr];
      bus.st_status_out <= stat_ram[bus.st_addr];
    end
    if (bus.d_we) begin
      data_ram[bus.d_addr] <= bus.d_in;
      d_we_cnt <= d_we_cnt + 1;
    end
    if (bus.d_re) bus.d_out <= data_ram[bus.d_addr];
    if ((bus.st_we && bus.st_re) || (bus.d_we && bus.d_re) ||
        (bus.st_we != bus.d_we) || (bus.st_re != bus.d_re))
      proto_err <= proto_err + 1;
  end

  // Backing memory
  logic [LINE_W-1:0] mem_store [logic [MADDR_W-1:0]];

  function automatic logic [LINE_W-1:0] mem_line(input logic [MADDR_W-1:0] a);
    logic [LINE_W-1:0] l;
    if (mem_store.exists(a)) return mem_store[a];
    if (a == 23'h4) return 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = 32'hC000_0000 | ({9'd0, a} << 4) | w;
    return l;
  endfunction

  int stall = 0;
  bit fill_hold = 0;
  int wcnt = 0, rcnt = 0;
  bit fill_pend = 0;
  logic [MADDR_W-1:0] fill_addr;
  int wb_cnt = 0, fill_cnt = 0, fill_done_cyc = 0;
  int bad_wb = 0, bad_fill = 0, resp_in_mem = 0;
  logic [MADDR_W-1:0] exp_wb_addr = '0, exp_fill_addr = '0;
  logic [LINE_W-1:0]  exp_wb_data = '0;

  always @(negedge clk) begin
    if (!reset) begin
      bus.mem_wready = 1'b0;
      bus.mem_rready = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      fill_pend = 0; wcnt = 0; rcnt = 0;
    end else begin
      bus.mem_rvalid = 1'b0;
      if (fill_pend && !fill_hold) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = mem_line(fill_addr);
        fill_pend = 0;
        fill_done_cyc = cyc;
      end
      bus.mem_wready = 1'b0;
      if (bus.mem_wvalid) begin
        if (bus.mem_waddr !== exp_wb_addr || bus.mem_wdata !== exp_wb_data) bad_wb++;
        if (wcnt >= stall) begin
          bus.mem_wready = 1'b1;
          mem_store[bus.mem_waddr] = bus.mem_wdata;
          wb_cnt++;
          wcnt = 0;
        end else wcnt++;
      end else wcnt = 0;
      bus.mem_rready = 1'b0;
      if (bus.mem_rvalid_req) begin
        if (bus.mem_raddr !== exp_fill_addr) bad_fill++;
        if (rcnt >= stall) begin
          bus.mem_rready = 1'b1;
          fill_pend = 1;
          fill_addr = bus.mem_raddr;
          fill_cnt++;
          rcnt = 0;
        end else rcnt++;
      end else rcnt = 0;
      if (bus.resp_valid && (bus.mem_wvalid || bus.mem_rvalid_req || fill_pend)) resp_in_mem++;
    end
  end

  // Response monitor
  logic [31:0] obs_q [$];
  logic [31:0] exp_q [$];
  int resp_seen = 0, resp_cyc = 0, req_cyc = 0;

  always @(negedge clk) begin
    if (bus.resp_valid) begin
      obs_q.push_back(bus.resp_rdata);
      resp_seen++;
      resp_cyc = cyc;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [26:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp);
    int n = 0;
    while (!bus.req_ready && n < 100) begin step(); n++; end
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    exp_q.push_back(exp);
    req_cyc = cyc;
    step();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
  endtask

  task automatic wait_resp(input string tag);
    int n = 0;
    logic [31:0] o, e;
    while (obs_q.size() == 0 && n < 400) begin step(); n++; end
    chk({tag, "_timeout"}, obs_q.size() > 0, 1);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk(tag, o, e);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  logic [LINE_W-1:0] line_exp;
  int st0, d0, r0, wb0, f0;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      tag_ram[i] = '0; stat_ram[i] = '0; data_ram[i] = '0;
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) step();

    // Reset state
    chk("rst_req_ready",  bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_st_re_we",   {bus.st_re, bus.st_we, bus.d_re, bus.d_we}, 0);
    chk("rst_mem_req",    {bus.mem_wvalid, bus.mem_rvalid_req}, 0);
`ifdef CACHE_CTRL_STATS_EN
    chk("rst_stats", {hit_cnt, miss_cnt}, 0);
`endif
    reset = 1'b1;
    repeat (2) step();

    // Cold read miss, clean victim
    exp_fill_addr = 23'h4;
    issue(1'b0, 27'h40, 32'd0, 32'hAAAAAAAA);
    wait_resp("cold_read");
    chk("cold_latency", resp_cyc - req_cyc, 5);
    chk("cold_no_wb", wb_cnt, 0);
    chk("cold_fill_cnt", fill_cnt, 1);
    chk("cold_status", stat_ram[4], 3'b001);
    chk("cold_tag", tag_ram[4], 0);
    chk("cold_line", data_ram[4], 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);

    // Read hit
    issue(1'b0, 27'h44, 32'd0, 32'hBBBBBBBB);
    wait_resp("hit_read");
    chk("hit_latency", resp_cyc - req_cyc, 2);
    chk("hit_no_mem", {wb_cnt, fill_cnt}, {32'd0, 32'd1});

    // Write hit
    issue(1'b1, 27'h48, 32'h12345678, 32'd0);
    wait_resp("hit_write");
    chk("hitw_latency", resp_cyc - req_cyc, 2);
    chk("hitw_status", stat_ram[4], 3'b011);
    chk("hitw_line", data_ram[4], 128'hDDDDDDDD_12345678_BBBBBBBB_AAAAAAAA);

    // Conflict read miss with dirty victim, both channels stalled
    stall       = 5;
    exp_wb_addr = 23'h4;
    exp_wb_data = 128'hDDDDDDDD_12345678_BBBBBBBB_AAAAAAAA;
    exp_fill_addr = 23'h404;
    issue(1'b0, 27'h404C, 32'd0, 32'hC0004043);
    wait_resp("dirty_miss");
    stall = 0;
    chk("dirty_latency", resp_cyc - req_cyc, 16);
    chk("dirty_wb_cnt", wb_cnt, 1);
    chk("dirty_fill_cnt", fill_cnt, 2);
    chk("dirty_wb_bad", bad_wb, 0);
    chk("dirty_fill_bad", bad_fill, 0);
    chk("dirty_wb_stored", mem_store.exists(23'h4) ? mem_store[23'h4] : '0, exp_wb_data);
    chk("dirty_order", fill_done_cyc < resp_cyc, 1);
    chk("dirty_status", stat_ram[4], 3'b001);
    chk("dirty_tag", tag_ram[4], 1);

    // Write miss on an empty index
    exp_fill_addr = 23'h10;
    line_exp = mem_line(23'h10);
    line_exp[64 +: 32] = 32'hCAFEF00D;
    issue(1'b1, 27'h108, 32'hCAFEF00D, 32'd0);
    wait_resp("write_miss");
    chk("wmiss_latency", resp_cyc - req_cyc, 5);
    chk("wmiss_no_wb", wb_cnt, 1);
    chk("wmiss_status", stat_ram[16], 3'b011);
    chk("wmiss_line", data_ram[16], line_exp);

    issue(1'b0, 27'h108, 32'd0, 32'hCAFEF00D);
    wait_resp("read_back");
    chk("readback_latency", resp_cyc - req_cyc, 2);
    chk("mem_resp_overlap", resp_in_mem, 0);
`ifdef CACHE_CTRL_STATS_EN
    chk("stats_hit", hit_cnt, 3);
    chk("stats_miss", miss_cnt, 3);
`endif

    // Reset while waiting for fill data
    fill_hold = 1;
    exp_fill_addr = 23'h20;
    f0 = fill_cnt;
    issue(1'b0, 27'h200, 32'd0, 32'd0);
    for (int n = 0; n < 50 && fill_cnt == f0; n++) step();
    step();
    chk("rstfw_in_wait", {bus.req_ready, bus.mem_rvalid_req, bus.resp_valid}, 0);
    st0 = st_we_cnt; d0 = d_we_cnt; r0 = resp_seen;
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("rstfw_ready", bus.req_ready, 1);
    chk("rstfw_outs", {bus.resp_valid, bus.st_we, bus.d_we, bus.mem_rvalid_req}, 0);
    repeat (3) step();
    reset = 1'b1;
    fill_hold = 0;
    repeat (6) step();
    chk("rstfw_no_resp", resp_seen, r0);
    chk("rstfw_no_st_we", st_we_cnt, st0);
    chk("rstfw_no_d_we", d_we_cnt, d0);
    chk("rstfw_status", stat_ram[32], 3'b000);
`ifdef CACHE_CTRL_STATS_EN
    chk("stats_cleared", {hit_cnt, miss_cnt}, 0);
`endif

    // Recovery: hit on the refilled conflicting line
    wb0 = wb_cnt;
    issue(1'b0, 27'h4044, 32'd0, 32'hC0004041);
    wait_resp("recover_hit");
    chk("recover_latency", resp_cyc - req_cyc, 2);
    chk("recover_no_wb", wb_cnt, wb0);
`ifdef CACHE_CTRL_STATS_EN
    chk("stats_after", {hit_cnt, miss_cnt}, {32'd1, 32'd0});
`endif

    repeat (3) step();
    chk("ram_protocol", proto_err, 0);
    chk("no_stray_resp", obs_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
